icache_linefill_rx: RTL
=======================

Name: icache_linefill_rx

Overview:
Response-side counterpart of the icache MSHR linefill request path.
- Accepts downstream linefill data beats tagged with the MSHR entry id that issued the linefill txreq.
- Assembles the beats into a full cacheline and writes it into the dataram at the entry's index and way.
- After the write completes, pulses the one-hot linefill_done bit for that entry, which releases the entry.
- Sits between the downstream rx data channel, the dataram write port and the MSHR entry array.

Parameters:
MSHR_ENTRY_NUM, 8, number of MSHR entries; also the width of the linefill_done vector.
ID_WIDTH, 3, width of rxdat_id; must satisfy 2^ID_WIDTH >= MSHR_ENTRY_NUM.
INDEX_WIDTH, 6, icache set index width.
BEAT_WIDTH, 256, data bits per downstream beat.
BEATS_PER_LINE, 2, beats per cacheline; must be at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rxdat_vld  in  1  downstream data beat valid
rxdat_rdy  out  1  beat accepted when rxdat_vld and rxdat_rdy are both high
rxdat_id  in  ID_WIDTH  MSHR entry id of the beat
rxdat_last  in  1  marks the final beat of a line
rxdat_data  in  BEAT_WIDTH  beat payload
mshr_index  in  MSHR_ENTRY_NUM*INDEX_WIDTH  per-entry set index; entry e is at [e*INDEX_WIDTH +: INDEX_WIDTH]
mshr_way  in  MSHR_ENTRY_NUM  per-entry destination way (2-way cache)
dataram_wr_vld  out  1  line write request
dataram_wr_rdy  in  1  dataram accepts the write
dataram_wr_index  out  INDEX_WIDTH  write set index
dataram_wr_way  out  1  write way
dataram_wr_data  out  BEATS_PER_LINE*BEAT_WIDTH  assembled line
linefill_done  out  MSHR_ENTRY_NUM  one-hot, single-cycle completion pulse
proto_err  out  1  single-cycle pulse when a line is discarded

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = COLLECT, beat_cnt = 0, bad_line = 0.
  - dataram_wr_vld = 0, linefill_done = 0, proto_err = 0.
  - Data, index and way registers = 0.
  - rxdat_rdy = 0 while rst is high.
- Only two states exist, COLLECT and WRITE. rxdat_rdy = (state == COLLECT) and not rst.
- Beats of one line arrive consecutively; no interleaving between ids.
- COLLECT, on each accepted beat:
  - Store the beat at line bits [beat_cnt*BEAT_WIDTH +: BEAT_WIDTH].
  - If beat_cnt == 0: latch id, mshr_index[id] and mshr_way[id].
  - Set bad_line if id >= MSHR_ENTRY_NUM.
  - Set bad_line if beat_cnt > 0 and id differs from the latched id.
  - Set bad_line if rxdat_last does not equal (beat_cnt == BEATS_PER_LINE-1).
- Line end occurs on an accepted beat with rxdat_last = 1, or on the beat where beat_cnt == BEATS_PER_LINE-1.
  - beat_cnt returns to 0. It otherwise increments, wrapping only at line end.
  - If bad_line (including the current beat): proto_err pulses the next cycle, no write is issued, state stays COLLECT, bad_line clears.
  - Otherwise: state moves to WRITE and dataram_wr_vld = 1 the next cycle.
- WRITE:
  - dataram_wr_vld stays high and index, way and data stay stable until dataram_wr_rdy.
  - rxdat_rdy = 0 throughout.
  - On the handshake: the next cycle has state = COLLECT and linefill_done[id] = 1 for exactly that cycle; all other bits are 0.
- Latency: final beat accepted at T; write valid at T+1; with rdy=1 at T+1, linefill_done and rxdat_rdy are both high at T+2.
- The mshr_index and mshr_way inputs are sampled only at beat 0; later changes have no effect.
- A reset asserted in any state aborts the line: no write and no linefill_done are issued. Outputs follow reset values in the cycle after rst is sampled high.

Test Plan:
1. Nominal line:
   - Setup: mshr_index[3]=0x15, mshr_way[3]=1, wr_rdy=1.
   - Stimulus: id=3, beats A (last=0) then B (last=1) at T-1 and T.
   - Required: T+1 wr_vld=1, index=0x15, way=1, data={B,A}; T+2 linefill_done=8'b0000_1000, rxdat_rdy=1.
2. Backpressure:
   - Stimulus: as scenario 1 with wr_rdy held low for 3 cycles.
   - Required: wr_vld high with stable payload for 4 cycles; rxdat_rdy=0; linefill_done pulses once, the cycle after rdy rises.
3. Early last:
   - Stimulus: id=2, single beat with last=1.
   - Required: proto_err=1 for one cycle; no wr_vld; the next line with id=2 of 2 beats completes normally.
4. Bad id:
   - Stimulus: ID_WIDTH=4, id=9, two beats.
   - Required: proto_err pulse after the second beat; no write; linefill_done stays 0.
5. Reset mid-WRITE:
   - Stimulus: rst asserted during WRITE with wr_rdy=0.
   - Required: next cycle wr_vld=0 and linefill_done=0; rxdat_rdy=1 after rst deasserts.
6. Back-to-back lines:
   - Stimulus: id=1 then id=6, each 2 beats, wr_rdy=1.
   - Required: two writes with the correct index and way each; linefill_done pulses 0x02 then 0x40; proto_err never asserts.

Source files
------------

// File: rtl/icache_linefill_rx.sv
// icache linefill response path: collects downstream data beats for one MSHR
// entry, writes the assembled line into the dataram at the entry's index/way,
// then pulses linefill_done for that entry. Malformed lines are dropped with
// a proto_err pulse.
module icache_linefill_rx #(
    parameter int MSHR_ENTRY_NUM = 8,
    parameter int ID_WIDTH       = 3,
    parameter int INDEX_WIDTH    = 6,
    parameter int BEAT_WIDTH     = 256,
    parameter int BEATS_PER_LINE = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rxdat_vld,
    output logic                                  rxdat_rdy,
    input  logic [ID_WIDTH-1:0]                   rxdat_id,
    input  logic                                  rxdat_last,
    input  logic [BEAT_WIDTH-1:0]                 rxdat_data,
    input  logic [MSHR_ENTRY_NUM*INDEX_WIDTH-1:0] mshr_index,
    input  logic [MSHR_ENTRY_NUM-1:0]             mshr_way,
    output logic                                  dataram_wr_vld,
    input  logic                                  dataram_wr_rdy,
    output logic [INDEX_WIDTH-1:0]                dataram_wr_index,
    output logic                                  dataram_wr_way,
    output logic [BEATS_PER_LINE*BEAT_WIDTH-1:0]  dataram_wr_data,
    output logic [MSHR_ENTRY_NUM-1:0]             linefill_done,
    output logic                                  proto_err
);

    localparam int CNT_WIDTH  = $clog2(BEATS_PER_LINE);
    localparam int LINE_WIDTH = BEATS_PER_LINE * BEAT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT   = CNT_WIDTH'(BEATS_PER_LINE - 1);
    localparam logic [ID_WIDTH:0]    ENTRY_LIMIT = (ID_WIDTH + 1)'(MSHR_ENTRY_NUM);

    typedef enum logic {
        COLLECT,
        WRITE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      beat_cnt_q;
    logic                      bad_line_q;
    logic [ID_WIDTH-1:0]       id_q;
    logic [INDEX_WIDTH-1:0]    index_q;
    logic                      way_q;
    logic [LINE_WIDTH-1:0]     line_q;
    logic [MSHR_ENTRY_NUM-1:0] done_q, done_d;
    logic                      proto_err_q;

    logic                      accept;
    logic                      at_last_cnt;
    logic                      id_oob;
    logic                      beat_bad;
    logic                      line_bad;
    logic                      line_end;
    logic [INDEX_WIDTH-1:0]    sel_index;
    logic                      sel_way;

    assign rxdat_rdy   = (state_q == COLLECT) && !rst;
    assign accept      = rxdat_vld && rxdat_rdy;
    assign at_last_cnt = (beat_cnt_q == LAST_BEAT);
    assign id_oob      = ({1'b0, rxdat_id} >= ENTRY_LIMIT);
    assign beat_bad    = id_oob
                       || ((beat_cnt_q != '0) && (rxdat_id != id_q))
                       || (rxdat_last != at_last_cnt);
    assign line_bad    = bad_line_q || beat_bad;
    assign line_end    = accept && (rxdat_last || at_last_cnt);

    // Look up the incoming id's index/way; out-of-range ids select zero
    always_comb begin
        sel_index = '0;
        sel_way   = 1'b0;
        for (int unsigned e = 0; e < MSHR_ENTRY_NUM; e++) begin
            if (32'(rxdat_id) == e) begin
                sel_index = mshr_index[e*INDEX_WIDTH +: INDEX_WIDTH];
                sel_way   = mshr_way[e];
            end
        end
    end

    // Next-state and one-hot completion decode
    always_comb begin
        state_d = state_q;
        done_d  = '0;
        case (state_q)
            COLLECT: begin
                if (line_end && !line_bad) state_d = WRITE;
            end
            WRITE: begin
                if (dataram_wr_rdy) begin
                    state_d = COLLECT;
                    for (int unsigned e = 0; e < MSHR_ENTRY_NUM; e++) begin
                        if (32'(id_q) == e) done_d[e] = 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    // Beat assembly, line bookkeeping and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            bad_line_q  <= 1'b0;
            id_q        <= '0;
            index_q     <= '0;
            way_q       <= 1'b0;
            line_q      <= '0;
            done_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            done_q      <= done_d;
            proto_err_q <= line_end && line_bad;
            if (accept) begin
                line_q[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= rxdat_data;
                if (beat_cnt_q == '0) begin
                    id_q    <= rxdat_id;
                    index_q <= sel_index;
                    way_q   <= sel_way;
                end
                if (line_end) begin
                    beat_cnt_q <= '0;
                    bad_line_q <= 1'b0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                    bad_line_q <= line_bad;
                end
            end
        end
    end

    assign dataram_wr_vld   = (state_q == WRITE);
    assign dataram_wr_index = index_q;
    assign dataram_wr_way   = way_q;
    assign dataram_wr_data  = line_q;
    assign linefill_done    = done_q;
    assign proto_err        = proto_err_q;

endmodule
